cmp_share_arb: RTL and testbench
================================

Name: cmp_share_arb

Overview:
- Round-robin arbiter and scheduler that shares one registered unsigned min-compare datapath between NREQ requesters.
- Each requester presents an operand pair (n1, n2) with a req/gnt handshake.
- The granted pair is compared and the result is returned one cycle later, tagged with the requester index, under valid/ready backpressure.
- Sits in front of the compare/min tree so several clients can reuse one comparator instead of instantiating their own.

Parameters:
- NREQ, 4, number of requesters (2..16).
- W, 8, operand and result width in bits.
- IDW, $clog2(NREQ), width of the requester index tag (localparam, derived).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  reset, synchronous, active-high (1 = reset); name kept per codebase convention.
- req  input  NREQ  per-requester request, bit i for requester i.
- n1_bus  input  NREQ*W  operand 1; requester i at bits [i*W +: W].
- n2_bus  input  NREQ*W  operand 2; requester i at bits [i*W +: W].
- gnt  output  NREQ  one-hot grant, combinational; transfer occurs when req[i] and gnt[i] are both 1.
- res_valid  output  1  result register holds a valid result.
- res_ready  input  1  consumer accepts the result this cycle.
- res_id  output  IDW  index of the requester the result belongs to.
- res  output  W  min(n1, n2) of the granted pair.

Behaviour:
- Reset (rst_n=1 at a clock edge):
  - ptr=0, res_valid=0, res=0, res_id=0.
  - gnt forced to 0 combinationally while rst_n=1.
  - A reset mid-operation discards any pending result and does not return it.
- Stall: stall = res_valid & ~res_ready. While stalled:
  - gnt=0.
  - res, res_id, res_valid and ptr hold.
- Arbitration, when not stalled and not in reset:
  - Search req starting at index ptr, ascending with wrap from NREQ-1 to 0.
  - The first set bit k gets gnt=(1<<k).
  - If req=0 then gnt=0.
- Pointer update: on a grant to k, ptr <= (k+1) mod NREQ at the clock edge; otherwise ptr holds.
- Datapath:
  - On a grant to k: res <= (n1_k < n2_k) ? n1_k : n2_k, unsigned compare; on equal operands res <= n2_k (value identical).
  - res_id <= k and res_valid <= 1.
  - Latency: grant cycle N, result visible cycle N+1.
- Retire: if res_valid & res_ready and there is no new grant, res_valid <= 0. res and res_id hold their old values.
- Simultaneous retire and grant: res_ready=1 with a new grant loads the new result the same edge, giving back-to-back throughput of 1 result per cycle.
- Requester rules:
  - A requester holds req, n1 and n2 stable until it sees gnt.
  - Deasserting req before a grant is legal; no transfer happens.
  - Operands are sampled only in the grant cycle.
- Fairness: a continuously requesting client is granted within NREQ grant opportunities.

Optional Feature:
- Macro CMP_MAX_SEL_EN.
- Defined:
  - Adds input op_bus [NREQ-1:0] and output res_op [0:0].
  - op_bus[k]=1 in the grant cycle selects max: res <= (n1_k > n2_k) ? n1_k : n2_k. op_bus[k]=0 selects min.
  - res_op <= op_bus[k], reset value 0, held under stall.
- Undefined:
  - op_bus and res_op are absent from the port list.
  - The block always computes min.

Test Plan:
- Reset and idle: rst_n=1 for 2 cycles with req=4'b1111 -> gnt=0, res_valid=0, res=0, res_id=0. Release with req=0 -> gnt stays 0.
- Single client: req=4'b0100, n1_2=8'h35, n2_2=8'h12 -> gnt=4'b0100 that cycle; next cycle res_valid=1, res=8'h12, res_id=2; ptr becomes 3.
- Round-robin: req=4'b1111 held, res_ready=1 -> grant sequence 0,1,2,3,0 on consecutive cycles. res_id follows one cycle later with res_valid continuously 1.
- Backpressure: result pending with res_ready=0 for 3 cycles and req=4'b0011 -> gnt=0 and res/res_id stable. Raise res_ready -> the next grant goes to the client at ptr and the pending result retires the same edge.
- Wrap and equality: ptr=3, req=4'b1001, n1_3=n2_3=8'hFF -> gnt=4'b1000, res=8'hFF, ptr wraps to 0. Next grant goes to 0.
- Reset mid-stall: res_valid=1, res_ready=0, rst_n pulsed 1 cycle -> res_valid=0, ptr=0. With CMP_MAX_SEL_EN: op_bus[1]=1, n1=8'h20, n2=8'h80 -> res=8'h80, res_op=1.

Source files
------------

// File: rtl/cmp_share_arb_if.sv
// cmp_share_arb_if: requester/result bundle for cmp_share_arb; CMP_MAX_SEL_EN adds op_bus/res_op.
interface cmp_share_arb_if #(
  parameter int NREQ = 4,
  parameter int W = 8
);
  localparam int IDW = $clog2(NREQ);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [NREQ*W-1:0] n1_bus;
  logic [NREQ*W-1:0] n2_bus;
  logic res_valid;
  logic res_ready;
  logic [IDW-1:0] res_id;
  logic [W-1:0] res;
`ifdef CMP_MAX_SEL_EN
  logic [NREQ-1:0] op_bus;
  logic [0:0] res_op;
  modport master (output req, n1_bus, n2_bus, op_bus, res_ready, input gnt, res_valid, res_id, res, res_op);
  modport slave (input req, n1_bus, n2_bus, op_bus, res_ready, output gnt, res_valid, res_id, res, res_op);
`else
  modport master (output req, n1_bus, n2_bus, res_ready, input gnt, res_valid, res_id, res);
  modport slave (input req, n1_bus, n2_bus, res_ready, output gnt, res_valid, res_id, res);
`endif
endinterface

// File: rtl/cmp_share_arb.sv
// cmp_share_arb: round-robin arbiter sharing one registered min compare; CMP_MAX_SEL_EN adds per-request max select.
module cmp_share_arb #(
  parameter int NREQ = 4,
  parameter int W = 8
) (
  input logic clk,
  input logic rst_n,
  cmp_share_arb_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
  localparam logic [IDW:0] N = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST = IDW'(NREQ-1);
  logic [IDW-1:0] ptr, k, id_q;
  logic [IDW:0] idx;
  logic found, stall, grant, valid_q;
  logic [W-1:0] a, b, lo, sel, res_q;
  assign stall = valid_q & ~bus.res_ready;
  // first requester at or after ptr, wrapping
  always_comb begin
    k = ptr;
    found = 1'b0;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, ptr} + (IDW+1)'(i);
      idx = (idx >= N) ? idx - N : idx;
      if (!found && bus.req[idx[IDW-1:0]]) begin
        k = idx[IDW-1:0];
        found = 1'b1;
      end
    end
  end
  assign grant = found & ~stall & ~rst_n;
  assign bus.gnt = grant ? NREQ'(1) << k : '0;
  assign a = bus.n1_bus[k*W +: W];
  assign b = bus.n2_bus[k*W +: W];
  assign lo = (a < b) ? a : b;
`ifdef CMP_MAX_SEL_EN
  logic [W-1:0] hi;
  logic op_q;
  assign hi = (a > b) ? a : b;
  assign sel = bus.op_bus[k] ? hi : lo;
  assign bus.res_op = op_q;
  always_ff @(posedge clk)
    if (rst_n) op_q <= 1'b0;
    else if (grant) op_q <= bus.op_bus[k];
`else
  assign sel = lo;
`endif
  always_ff @(posedge clk) begin
    if (rst_n) begin
      ptr <= '0;
      valid_q <= 1'b0;
      res_q <= '0;
      id_q <= '0;
    end else if (grant) begin
      ptr <= (k == LAST) ? '0 : k + IDW'(1);
      valid_q <= 1'b1;
      res_q <= sel;
      id_q <= k;
    end else if (bus.res_ready) begin
      valid_q <= 1'b0;
    end
  end
  assign bus.res_valid = valid_q;
  assign bus.res = res_q;
  assign bus.res_id = id_q;
endmodule

// File: tb/tb_cmp_share_arb.sv
// tb_cmp_share_arb: randomized scoreboard bench for cmp_share_arb against a round-robin reference model.
module tb_cmp_share_arb;
  localparam int NREQ = 4;
  localparam int W = 8;
  typedef struct {
    int id;
    int val;
    int op;
  } item_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  cmp_share_arb_if #(.NREQ(NREQ), .W(W)) bus ();
  cmp_share_arb #(.NREQ(NREQ), .W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  item_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  logic [NREQ-1:0] req, ops;
  logic [W-1:0] n1[NREQ], n2[NREQ];
  logic ready;
  int mptr = 0;
  bit mvalid = 1'b0;
  int last_g = -1;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive();
    bus.req = req;
    bus.res_ready = ready;
    for (int i = 0; i < NREQ; i++) begin
      bus.n1_bus[i*W +: W] = n1[i];
      bus.n2_bus[i*W +: W] = n2[i];
    end
`ifdef CMP_MAX_SEL_EN
    bus.op_bus = ops;
`endif
  endtask
  // one clock: check the grant against the model, then book the expected result
  task automatic step();
    int eg;
    int v1, v2, want_max;
    item_t it;
    drive();
    @(negedge clk);
    eg = -1;
    if (!rst_n && !(mvalid && !ready))
      for (int d = 0; d < NREQ; d++)
        if (eg < 0 && req[(mptr + d) % NREQ]) eg = (mptr + d) % NREQ;
    chk("gnt", {28'd0, bus.gnt}, eg < 0 ? 0 : 1 << eg);
    @(posedge clk);
    if (rst_n) begin
      mvalid = 1'b0;
      mptr = 0;
      q.delete();
    end else if (eg >= 0) begin
      v1 = int'(n1[eg]);
      v2 = int'(n2[eg]);
`ifdef CMP_MAX_SEL_EN
      want_max = int'(ops[eg]);
`else
      want_max = 0;
`endif
      it.id = eg;
      it.op = want_max;
      it.val = want_max != 0 ? (v1 > v2 ? v1 : v2) : (v1 < v2 ? v1 : v2);
      q.push_back(it);
      mptr = (eg + 1) % NREQ;
      mvalid = 1'b1;
    end else if (ready) begin
      mvalid = 1'b0;
    end
    last_g = eg;
    #1;
  endtask
  initial begin
    forever begin
      @(negedge clk);
      if (bus.res_valid === 1'b1) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_result: res_valid=1 with nothing expected at %0t", $time);
        end else begin
          chk("res", {24'd0, bus.res}, q[0].val);
          chk("res_id", {30'd0, bus.res_id}, q[0].id);
`ifdef CMP_MAX_SEL_EN
          chk("res_op", {31'd0, bus.res_op}, q[0].op);
`endif
          if (bus.res_ready) void'(q.pop_front());
        end
      end else begin
        chk("pending_lost", q.size(), 0);
      end
    end
  end
  initial begin
    req = 4'b1111;
    ops = '0;
    ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      n1[i] = W'($urandom);
      n2[i] = W'($urandom);
    end
    step();
    step();
    chk("rst_valid", {31'd0, bus.res_valid}, 0);
    chk("rst_res", {24'd0, bus.res}, 0);
    chk("rst_id", {30'd0, bus.res_id}, 0);
    rst_n = 1'b0;
    req = '0;
    step();
    req = 4'b0100;
    n1[2] = 8'h35;
    n2[2] = 8'h12;
    step();
    chk("single_valid", {31'd0, bus.res_valid}, 1);
    chk("single_res", {24'd0, bus.res}, 32'h12);
    chk("single_id", {30'd0, bus.res_id}, 2);
    req = 4'b1111;
    repeat (5) step();
    ready = 1'b0;
    req = 4'b0011;
    repeat (3) step();
    ready = 1'b1;
    step();
    req = '0;
    step();
    req = 4'b0100;
    step();
    req = 4'b1001;
    n1[3] = 8'hFF;
    n2[3] = 8'hFF;
    step();
    chk("wrap_res", {24'd0, bus.res}, 32'hFF);
    chk("wrap_id", {30'd0, bus.res_id}, 3);
    req = 4'b0001;
    step();
    ready = 1'b0;
    req = '0;
    step();
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    chk("midrst_valid", {31'd0, bus.res_valid}, 0);
    ready = 1'b1;
    req = 4'b0010;
    ops = 4'b0010;
    n1[1] = 8'h20;
    n2[1] = 8'h80;
    step();
    req = '0;
    step();
    repeat (3000) begin
      for (int i = 0; i < NREQ; i++) begin
        if (last_g == i || !req[i]) begin
          req[i] = 1'($urandom_range(0, 1));
          n1[i] = W'($urandom);
          n2[i] = ($urandom_range(0, 7) == 0) ? n1[i] : W'($urandom);
          ops[i] = 1'($urandom);
        end else if ($urandom_range(0, 9) == 0) begin
          req[i] = 1'b0;
        end
      end
      ready = $urandom_range(0, 3) != 0;
      rst_n = $urandom_range(0, 299) == 0;
      step();
    end
    rst_n = 1'b0;
    req = '0;
    ready = 1'b1;
    repeat (3) step();
    chk("drain", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
